dcache: RTL and testbench
=========================

// Module: dcache
// PURPOSE
//   Direct-mapped, write-back, write-allocate data cache between the CPU memory-access (MA) stage and main data memory.
//   Consumes the CPU DMEM address/data/read/write bus and returns load data (sign/zero-extended) plus BUSYWAIT, which stalls all CPU pipeline registers.
//   Talks to main memory by whole blocks over a busywait handshake.
// PARAMETERS
//   NUM_LINES    8   number of cache lines (power of 2); INDEX_W = log2(NUM_LINES)
//   BLOCK_WORDS  4   32-bit words per line (power of 2); OFFSET_W = 2 + log2(BLOCK_WORDS)
//   TAG_W = 32 - INDEX_W - OFFSET_W (derived localparam, 25 at defaults)
// PORTS
//   CLK            in   1              clock, all state updates on posedge
//   RST            in   1              synchronous, active-high reset
//   ADDRESS        in   32             byte address from MA stage (ALU result)
//   WRITE_DATA     in   32             store data (rs2)
//   MEM_READ_IN    in   4              [3]=load req, [2:0]=funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   MEM_WRITE_IN   in   3              [2]=store req, [1:0]=funct3[1:0]: 00 SB, 01 SH, 10 SW
//   READ_DATA      out  32             extended load result
//   BUSYWAIT       out  1              stall request to CPU
//   MEM_ADDR       out  32-OFFSET_W    block address to main memory
//   MEM_WRITEDATA  out  32*BLOCK_WORDS victim block
//   MEM_READDATA   in   32*BLOCK_WORDS fill block
//   MEM_READ       out  1              block read request
//   MEM_WRITE      out  1              block write request
//   MEM_BUSYWAIT   in   1              high while memory busy; low in completing cycle
// BEHAVIOUR
//   - Reset: all valid/dirty bits 0, state IDLE, MEM_READ=MEM_WRITE=0, BUSYWAIT=0, READ_DATA=0. Data/tag arrays need not be cleared.
//   - Address split: tag=ADDRESS[31:32-TAG_W], index=next INDEX_W bits, word=ADDRESS[OFFSET_W-1:2].
//   - Halfword lane: ADDRESS[1]. Byte lane: ADDRESS[1:0]. Misaligned bits are ignored (no trap).
//   - req = MEM_READ_IN[3] | MEM_WRITE_IN[2]. If both are set, the access is a store and READ_DATA=0.
//   - hit = valid[index] & (tag_array[index]==tag).
//   - BUSYWAIT (combinational) = (req & ~hit) | (state != IDLE). It must settle the same cycle the request appears.
//   - READ_DATA (combinational) on load hit:
//       LB/LH sign-extend; LBU/LHU zero-extend; LW whole word.
//       0 when there is no load or on a miss.
//   - Store hit: on posedge, write only the selected byte/half/word lanes of the line and set dirty. BUSYWAIT stays 0 (zero-stall hit).
//   - States: IDLE, WRITEBACK, FETCH, UPDATE.
//       IDLE: req & ~hit & dirty -> WRITEBACK; req & ~hit & ~dirty -> FETCH; otherwise stay.
//       WRITEBACK: MEM_WRITE=1, MEM_ADDR={victim tag,index}, MEM_WRITEDATA=line. On a cycle with MEM_BUSYWAIT=0 -> FETCH.
//       FETCH: MEM_READ=1, MEM_ADDR={req tag,index}. On a cycle with MEM_BUSYWAIT=0, capture MEM_READDATA -> UPDATE.
//       UPDATE: write line+tag, valid=1, dirty=0 -> IDLE. The access then hits; a pending store merges on that hit.
//   - MEM_READ/MEM_WRITE are never asserted together. Each drops the edge after its completing cycle.
//   - Latency (memory completes N cycles after request): clean miss = N+2 stall cycles; dirty miss = 2N+2 stall cycles.
//   - CPU holds ADDRESS/controls stable while BUSYWAIT=1; the cache does not re-latch them.
//   - RST asserted mid-miss: next edge -> IDLE, requests dropped, all lines invalid. No partial line is written.
// CONFIGURATION
//   DCACHE_STATS_EN defined:
//     adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0], both 0 on reset.
//     A request in IDLE with hit counts +1 hit. Entry IDLE->WRITEBACK/FETCH counts +1 miss; the post-UPDATE hit is not counted.
//     Both counters wrap at 2^32.
//   DCACHE_STATS_EN undefined: those ports and counters do not exist; behaviour otherwise identical.
// TESTING (memory model latency N=5)
//   1. After RST, LW 0x0000_0040 -> BUSYWAIT=1 for 7 cycles. MEM_READ with MEM_ADDR=0x000_0004.
//      Then READ_DATA = word 0 of fill; a repeat LW hits with BUSYWAIT=0.
//   2. SW 0xDEADBEEF @0x40, then LB @0x43 -> 0xFFFFFFDE; LBU @0x43 -> 0x000000DE; LH @0x42 -> 0xFFFFDEAD.
//      SB 0x12 @0x41 then LW @0x40 -> 0xDEAD12EF.
//   3. Dirty line at index 4, then LW 0x0000_00C0 (same index, new tag):
//      MEM_WRITE with old block first, then MEM_READ; 12 stall cycles; dirty cleared.
//   4. RST pulsed during FETCH -> MEM_READ=0 and BUSYWAIT=0 next cycle. A repeat of the earlier hit address now misses.
//   5. Both MEM_READ_IN[3] and MEM_WRITE_IN[2] set on a hit -> store performed, READ_DATA=0.
//   6. With DCACHE_STATS_EN: sequence miss, hit, hit, store-hit -> HIT_COUNT=3, MISS_COUNT=1.

Source files
------------

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache sitting between the
// CPU memory-access stage and block-oriented main memory.
// Optional feature macro: DCACHE_STATS_EN adds HIT_COUNT / MISS_COUNT outputs.
module dcache #(
    parameter int NUM_LINES   = 8,
    parameter int BLOCK_WORDS = 4,
    localparam int INDEX_W  = $clog2(NUM_LINES),
    localparam int WORD_W   = $clog2(BLOCK_WORDS),
    localparam int OFFSET_W = 2 + WORD_W,
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W,
    localparam int LINE_W   = 32 * BLOCK_WORDS
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           ADDRESS,
    input  logic [31:0]           WRITE_DATA,
    input  logic [3:0]            MEM_READ_IN,
    input  logic [2:0]            MEM_WRITE_IN,
    output logic [31:0]           READ_DATA,
    output logic                  BUSYWAIT,
`ifdef DCACHE_STATS_EN
    output logic [31:0]           HIT_COUNT,
    output logic [31:0]           MISS_COUNT,
`endif
    output logic [31-OFFSET_W:0]  MEM_ADDR,
    output logic [LINE_W-1:0]     MEM_WRITEDATA,
    input  logic [LINE_W-1:0]     MEM_READDATA,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    input  logic                  MEM_BUSYWAIT
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t state, next_state;

    logic [LINE_W-1:0]    data_array [NUM_LINES];
    logic [TAG_W-1:0]     tag_array  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [LINE_W-1:0]    fill_buf;

    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   req_index;
    logic [WORD_W-1:0]    req_word;
    logic [1:0]           lane;
    logic                 is_store;
    logic                 is_load;
    logic                 req;
    logic                 hit;
    logic                 store_hit;
    logic [LINE_W-1:0]    cur_line;
    logic [31:0]          cur_word;

    // Sign/zero extension of the selected byte or halfword for a load.
    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  ln);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = w[{ln, 3'b000} +: 8];
        h = ln[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = b;                       // LB: signed widening
            3'b001:  r = h;                       // LH: signed widening
            3'b010:  r = w;
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Merge store data into the existing word on the addressed lanes only.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [1:0]  f2,
                                                input logic [1:0]  ln);
        logic [31:0] r;
        r = old;
        case (f2)
            2'b00:   r[{ln, 3'b000} +: 8] = wd[7:0];
            2'b01:   r = ln[1] ? {wd[15:0], old[15:0]} : {old[31:16], wd[15:0]};
            2'b10:   r = wd;
            default: r = old;
        endcase
        return r;
    endfunction

    assign req_tag   = ADDRESS[31 -: TAG_W];
    assign req_index = ADDRESS[OFFSET_W +: INDEX_W];
    assign req_word  = ADDRESS[2 +: WORD_W];
    assign lane      = ADDRESS[1:0];

    // A simultaneous load+store request is treated as a store.
    assign is_store  = MEM_WRITE_IN[2];
    assign is_load   = MEM_READ_IN[3] & ~is_store;
    assign req       = MEM_READ_IN[3] | MEM_WRITE_IN[2];

    assign cur_line  = data_array[req_index];
    assign cur_word  = cur_line[{req_word, 5'b00000} +: 32];
    assign hit       = valid[req_index] && (tag_array[req_index] == req_tag);
    assign store_hit = (state == IDLE) && is_store && hit;

    assign BUSYWAIT  = (req && !hit) || (state != IDLE);
    assign READ_DATA = (is_load && hit) ? load_extend(cur_word, MEM_READ_IN[2:0], lane) : 32'b0;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode and memory-side handshake outputs.
    always_comb begin
        next_state    = state;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDR      = {req_tag, req_index};
        MEM_WRITEDATA = cur_line;
        case (state)
            IDLE: begin
                if (req && !hit) next_state = dirty[req_index] ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
                MEM_WRITE = 1'b1;
                MEM_ADDR  = {tag_array[req_index], req_index};
                if (!MEM_BUSYWAIT) next_state = FETCH;
            end
            FETCH: begin
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) next_state = UPDATE;
            end
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Valid/dirty bookkeeping: fill marks clean, store hit marks dirty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= '0;
            dirty <= '0;
        end else if (state == UPDATE) begin
            valid[req_index] <= 1'b1;
            dirty[req_index] <= 1'b0;
        end else if (store_hit) begin
            dirty[req_index] <= 1'b1;
        end
    end

    // Capture the fill block in the cycle memory completes the read.
    always_ff @(posedge CLK) begin
        if (state == FETCH && !MEM_BUSYWAIT) fill_buf <= MEM_READDATA;
    end

    // Data/tag arrays: whole-line fill or lane-masked store; suppressed under reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == UPDATE) begin
                data_array[req_index] <= fill_buf;
                tag_array[req_index]  <= req_tag;
            end else if (store_hit) begin
                data_array[req_index][{req_word, 5'b00000} +: 32] <=
                    store_merge(cur_word, WRITE_DATA, MEM_WRITE_IN[1:0], lane);
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic post_fill;

    // Hit/miss counters; the hit that completes a refill is not counted again.
    always_ff @(posedge CLK) begin
        if (RST) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
            post_fill  <= 1'b0;
        end else begin
            post_fill <= (state == UPDATE);
            if (state == IDLE && req) begin
                if (hit && !post_fill) HIT_COUNT  <= HIT_COUNT + 32'd1;
                else if (!hit)         MISS_COUNT <= MISS_COUNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache with a block memory model of fixed latency.
module tb_dcache;

    localparam int N = 5;

    logic         CLK = 1'b0;
    logic         RST;
    logic [31:0]  ADDRESS;
    logic [31:0]  WRITE_DATA;
    logic [3:0]   MEM_READ_IN;
    logic [2:0]   MEM_WRITE_IN;
    logic [31:0]  READ_DATA;
    logic         BUSYWAIT;
    logic [27:0]  MEM_ADDR;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic         MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;
`endif

    always #5 CLK = ~CLK;

    dcache dut (
        .CLK(CLK), .RST(RST), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .MEM_READ_IN(MEM_READ_IN), .MEM_WRITE_IN(MEM_WRITE_IN),
        .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT),
`ifdef DCACHE_STATS_EN
        .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT),
`endif
        .MEM_ADDR(MEM_ADDR), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    // ---------------- memory model ----------------
    logic [127:0] mem [64];
    bit           mem_ready;
    int           mcnt;
    logic         mem_req;

    function automatic logic [31:0] fill_word(input int b, input int k);
        return 32'hA000_0000 | 32'(b << 8) | 32'(k);
    endfunction

    assign mem_req      = MEM_READ | MEM_WRITE;
    assign MEM_BUSYWAIT = mem_req && (mcnt != N - 1);
    assign MEM_READDATA = mem[MEM_ADDR[5:0]];

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int b = 0; b < 64; b++)
                for (int k = 0; k < 4; k++)
                    mem[b][k*32 +: 32] <= fill_word(b, k);
            mem_ready <= 1'b1;
        end else if (MEM_WRITE && mcnt == N - 1) begin
            mem[MEM_ADDR[5:0]] <= MEM_WRITEDATA;
        end
        if (!mem_req || mcnt == N - 1) mcnt <= 0;
        else                           mcnt <= mcnt + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Per-access observations of the memory side.
    int           stalls;
    int           first_wr;
    int           first_rd;
    logic [27:0]  wr_addr;
    logic [27:0]  rd_addr;
    logic [127:0] wr_data;
    int           both_seen;

    // Present one request, then sample every stall cycle at the falling edge
    // until BUSYWAIT drops; returns at the falling edge of the hit cycle.
    task automatic do_access(input logic [31:0] addr, input logic [3:0] rd,
                             input logic [2:0] wr, input logic [31:0] wd);
        stalls    = 0;
        first_wr  = -1;
        first_rd  = -1;
        both_seen = 0;
        wr_addr   = '0;
        rd_addr   = '0;
        wr_data   = '0;
        @(posedge CLK); #1;
        ADDRESS = addr; MEM_READ_IN = rd; MEM_WRITE_IN = wr; WRITE_DATA = wd;
        #4;
        while (BUSYWAIT) begin
            if (MEM_WRITE && first_wr < 0) begin first_wr = stalls; wr_addr = MEM_ADDR; wr_data = MEM_WRITEDATA; end
            if (MEM_READ && first_rd < 0)  begin first_rd = stalls; rd_addr = MEM_ADDR; end
            if (MEM_READ && MEM_WRITE) both_seen++;
            stalls++;
            if (stalls > 100) begin
                check("access_timeout", 32'(stalls), 32'd0);
                break;
            end
            @(posedge CLK); #5;
        end
    endtask

    task automatic idle_cycle();
        @(posedge CLK); #1;
        MEM_READ_IN = 4'b0; MEM_WRITE_IN = 3'b0;
        #4;
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string nm, input logic [31:0] a, input logic [3:0] rd,
                           input logic [2:0] wr, input logic [31:0] wd, input logic [31:0] ex);
        vec_t v;
        v.name = nm; v.addr = a; v.rd = rd; v.wr = wr; v.wdata = wd; v.exp_data = ex;
        vq.push_back(v);
    endtask

    initial begin
        RST = 1'b1; ADDRESS = '0; WRITE_DATA = '0; MEM_READ_IN = '0; MEM_WRITE_IN = '0;

        // Hit-path vectors on line 4 (filled by the first miss).
        add_vec("sw_40",     32'h40, 4'b0000, 3'b110, 32'hDEADBEEF, 32'h0);
        add_vec("lb_43",     32'h43, 4'b1000, 3'b000, 32'h0,        32'hFFFFFFDE);
        add_vec("lbu_43",    32'h43, 4'b1100, 3'b000, 32'h0,        32'h000000DE);
        add_vec("lh_42",     32'h42, 4'b1001, 3'b000, 32'h0,        32'hFFFFDEAD);
        add_vec("lhu_42",    32'h42, 4'b1101, 3'b000, 32'h0,        32'h0000DEAD);
        add_vec("lb_40",     32'h40, 4'b1000, 3'b000, 32'h0,        32'hFFFFFFEF);
        add_vec("sb_41",     32'h41, 4'b0000, 3'b100, 32'hAAAA5512, 32'h0);
        add_vec("lw_40",     32'h40, 4'b1010, 3'b000, 32'h0,        32'hDEAD12EF);
        add_vec("sh_46",     32'h46, 4'b0000, 3'b101, 32'h12345678, 32'h0);
        add_vec("lw_44",     32'h44, 4'b1010, 3'b000, 32'h0,        32'h56780401);
        add_vec("lh_44",     32'h44, 4'b1001, 3'b000, 32'h0,        32'h00000401);
        add_vec("lw_4c",     32'h4C, 4'b1010, 3'b000, 32'h0,        32'hA0000403);
        add_vec("ld_st_48",  32'h48, 4'b1010, 3'b110, 32'hCAFEF00D, 32'h0);
        add_vec("lw_48",     32'h48, 4'b1010, 3'b000, 32'h0,        32'hCAFEF00D);

        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        #4;
        check("rst_busywait",  32'(BUSYWAIT),  32'd0);
        check("rst_read_data", READ_DATA,      32'd0);
        check("rst_mem_read",  32'(MEM_READ),  32'd0);
        check("rst_mem_write", 32'(MEM_WRITE), 32'd0);

        // Clean miss after reset.
        do_access(32'h40, 4'b1010, 3'b000, 32'h0);
        check("miss1_stalls",   32'(stalls),   32'd7);
        check("miss1_rd_addr",  32'(rd_addr),  32'h4);
        check("miss1_rd_first", 32'(first_rd), 32'd1);
        check("miss1_no_write", 32'(first_wr), 32'hFFFFFFFF);
        check("miss1_data",     READ_DATA,     32'hA0000400);
        do_access(32'h40, 4'b1010, 3'b000, 32'h0);
        check("rehit_stalls",   32'(stalls),   32'd0);
        check("rehit_data",     READ_DATA,     32'hA0000400);

        // Table of zero-stall hits.
        foreach (vq[i]) begin
            do_access(vq[i].addr, vq[i].rd, vq[i].wr, vq[i].wdata);
            check({vq[i].name, "_stalls"}, 32'(stalls), 32'd0);
            check({vq[i].name, "_data"},   READ_DATA,   vq[i].exp_data);
        end

        // Dirty miss: line 4 evicted by tag 1.
        do_access(32'hC0, 4'b1010, 3'b000, 32'h0);
        check("dirty_stalls",   32'(stalls),   32'd12);
        check("dirty_wr_first", 32'(first_wr), 32'd1);
        check("dirty_rd_first", 32'(first_rd), 32'd6);
        check("dirty_wr_addr",  32'(wr_addr),  32'h4);
        check("dirty_rd_addr",  32'(rd_addr),  32'hC);
        check("dirty_wdata_w0", wr_data[31:0],   32'hDEAD12EF);
        check("dirty_wdata_w1", wr_data[63:32],  32'h56780401);
        check("dirty_wdata_w2", wr_data[95:64],  32'hCAFEF00D);
        check("dirty_wdata_w3", wr_data[127:96], 32'hA0000403);
        check("dirty_both",     32'(both_seen), 32'd0);
        check("dirty_data",     READ_DATA,      32'hA0000C00);

        // Refilled line must be clean: evicting it again needs no writeback.
        do_access(32'h40, 4'b1010, 3'b000, 32'h0);
        check("clean_stalls",   32'(stalls),   32'd7);
        check("clean_no_write", 32'(first_wr), 32'hFFFFFFFF);
        check("clean_data",     READ_DATA,     32'hDEAD12EF);

        // Reset in the middle of a fetch.
        @(posedge CLK); #1;
        ADDRESS = 32'h80; MEM_READ_IN = 4'b1010; MEM_WRITE_IN = 3'b000;
        repeat (3) @(posedge CLK);
        #4;
        check("midrst_fetching", 32'(MEM_READ), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1; MEM_READ_IN = 4'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        #4;
        check("midrst_mem_read",  32'(MEM_READ),  32'd0);
        check("midrst_mem_write", 32'(MEM_WRITE), 32'd0);
        check("midrst_busywait",  32'(BUSYWAIT),  32'd0);
        check("midrst_rdata",     READ_DATA,      32'd0);
        do_access(32'h40, 4'b1010, 3'b000, 32'h0);
        check("postrst_40_stalls", 32'(stalls), 32'd7);
        check("postrst_40_data",   READ_DATA,   32'hDEAD12EF);
        do_access(32'h80, 4'b1010, 3'b000, 32'h0);
        check("postrst_80_stalls", 32'(stalls), 32'd7);
        check("postrst_80_addr",   32'(rd_addr), 32'h8);
        check("postrst_80_data",   READ_DATA,    32'hA0000800);

        // Counter sequence: miss, hit, hit, store-hit.
        idle_cycle();
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        #4;
`ifdef DCACHE_STATS_EN
        check("stats_rst_hit",  HIT_COUNT,  32'd0);
        check("stats_rst_miss", MISS_COUNT, 32'd0);
`endif
        do_access(32'h20, 4'b1010, 3'b000, 32'h0);
        check("seq_miss_stalls", 32'(stalls), 32'd7);
        check("seq_miss_data",   READ_DATA,   32'hA0000200);
        do_access(32'h24, 4'b1010, 3'b000, 32'h0);
        check("seq_hit1_data",   READ_DATA,   32'hA0000201);
        do_access(32'h28, 4'b1010, 3'b000, 32'h0);
        check("seq_hit2_data",   READ_DATA,   32'hA0000202);
        do_access(32'h2C, 4'b0000, 3'b110, 32'h11223344);
        check("seq_st_stalls",   32'(stalls), 32'd0);
        idle_cycle();
`ifdef DCACHE_STATS_EN
        check("stats_hit",  HIT_COUNT,  32'd3);
        check("stats_miss", MISS_COUNT, 32'd1);
`endif
        do_access(32'h2C, 4'b1010, 3'b000, 32'h0);
        check("seq_st_readback", READ_DATA, 32'h11223344);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
